// File: rtl/risc_dmem_arbiter.sv
// Round-robin arbiter and IDLE/ACCESS/DONE sequencer sharing the 16 x 8 data memory
// between the CPU load/store stage (A) and the DMA/debug port (B).
module risc_dmem_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_rdwr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_grant,
  input  logic              b_req,
  input  logic              b_rdwr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_grant,
  output logic              dmenbl,
  output logic [ADDR_W-1:0] dmaddr,
  output logic [DATA_W-1:0] dmdatain,
  output logic              rdwr,
  input  logic [DATA_W-1:0] dmdataout
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            r_state;
  logic              r_last_b;
  logic              r_a_ack;
  logic              r_b_ack;
  logic              r_a_grant;
  logic              r_b_grant;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_dmenbl;
  logic              r_rdwr;
  logic [ADDR_W-1:0] r_dmaddr;
  logic [DATA_W-1:0] r_dmdatain;
  logic              w_win_b;

  // B wins when alone, or on a tie when A was granted last.
  assign w_win_b = b_req & (~a_req | ~r_last_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_last_b   <= 1'b1;
      r_a_ack    <= 1'b0;
      r_b_ack    <= 1'b0;
      r_a_grant  <= 1'b0;
      r_b_grant  <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
      r_dmenbl   <= 1'b0;
      r_rdwr     <= 1'b1;
      r_dmaddr   <= '0;
      r_dmdatain <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (a_req || b_req) begin
            r_last_b   <= w_win_b;
            r_a_grant  <= ~w_win_b;
            r_b_grant  <= w_win_b;
            r_dmaddr   <= w_win_b ? b_addr  : a_addr;
            r_dmdatain <= w_win_b ? b_wdata : a_wdata;
            r_rdwr     <= w_win_b ? b_rdwr  : a_rdwr;
            r_dmenbl   <= 1'b1;
            r_state    <= StAccess;
          end
        end
        StAccess: begin
          if (r_rdwr) begin
            if (r_b_grant) r_b_rdata <= dmdataout;
            else           r_a_rdata <= dmdataout;
          end
          // Return to read direction so the level-sensitive write strobe closes.
          r_rdwr   <= 1'b1;
          r_dmenbl <= 1'b0;
          r_a_ack  <= r_a_grant;
          r_b_ack  <= r_b_grant;
          r_state  <= StDone;
        end
        StDone: begin
          r_a_ack   <= 1'b0;
          r_b_ack   <= 1'b0;
          r_a_grant <= 1'b0;
          r_b_grant <= 1'b0;
          r_state   <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign a_ack    = r_a_ack;
  assign b_ack    = r_b_ack;
  assign a_grant  = r_a_grant;
  assign b_grant  = r_b_grant;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;
  assign dmenbl   = r_dmenbl;
  assign rdwr     = r_rdwr;
  assign dmaddr   = r_dmaddr;
  assign dmdatain = r_dmdatain;

endmodule
